cpu_clock_control: RTL and testbench

CPU_CLOCK_CONTROL -- requirements
Module: cpu_clock_control

---
 rtl/tiny16_pkg.sv | 12 +
 rtl/debouncer.sv | 44 ++++
 rtl/cpu_clock_control.sv | 124 ++++++++++++
 tb/tb_cpu_clock_control.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tiny16_pkg.sv
// Shared tiny16 definitions: clock-control FSM state encoding and counter width.
package tiny16_pkg;

   typedef enum logic [1:0] {
      HALTED     = 2'd0,
      RUNNING    = 2'd1,
      STEP_ARMED = 2'd2
   } clkctl_state_t;

   localparam int unsigned CYCLE_COUNT_W = 32;

endpackage

// File: rtl/debouncer.sv
// Button debouncer: 2-flop synchronizer, stability counter, one-cycle press pulse.
// A new level is adopted only after it has held for 2^DEBOUNCE_BITS-1 cycles.
module debouncer #(
   parameter int unsigned DEBOUNCE_BITS = 16
) (
   input  logic clk_in,
   input  logic rst,
   input  logic i_btn,
   output logic o_press
);

   logic                     r_sync1;
   logic                     r_sync2;
   logic                     r_db;
   logic                     r_press;
   logic [DEBOUNCE_BITS-1:0] r_cnt;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_db    <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == '1) begin
            // Only a 0->1 adoption is a press; releases are silent.
            r_db    <= r_sync2;
            r_press <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/cpu_clock_control.sv
// CPU clock-enable generator with run/halt/single-step control.
// Optional macro CLKCTL_CYCLE_COUNT_EN builds the 32-bit cpu_ce pulse counter.
module cpu_clock_control
   import tiny16_pkg::*;
#(
   parameter int unsigned DEBOUNCE_BITS = 16,
   parameter int unsigned RUN_ON_RESET  = 0
) (
   input  logic                     clk_in,
   input  logic                     rst,
   input  logic                     tick_in,
   input  logic                     run_btn,
   input  logic                     step_btn,
   input  logic                     halt_req,
   output logic                     cpu_ce,
   output logic                     running,
   output logic [CYCLE_COUNT_W-1:0] cycle_count
);

   logic          r_tick_s1;
   logic          r_tick_s2;
   logic          r_tick_prev;
   logic          w_tick_edge;
   logic          w_run_press;
   logic          w_step_press;
   clkctl_state_t r_state;
   logic          r_cpu_ce;
   logic          r_running;

   debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_run_db (
      .clk_in  (clk_in),
      .rst     (rst),
      .i_btn   (run_btn),
      .o_press (w_run_press)
   );

   debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_step_db (
      .clk_in  (clk_in),
      .rst     (rst),
      .i_btn   (step_btn),
      .o_press (w_step_press)
   );

   // tick_in is plain asynchronous data; it never clocks anything.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_tick_s1   <= 1'b0;
         r_tick_s2   <= 1'b0;
         r_tick_prev <= 1'b0;
      end else begin
         r_tick_s1   <= tick_in;
         r_tick_s2   <= r_tick_s1;
         r_tick_prev <= r_tick_s2;
      end
   end

   assign w_tick_edge = r_tick_s2 & ~r_tick_prev;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state   <= (RUN_ON_RESET != 0) ? RUNNING : HALTED;
         r_running <= (RUN_ON_RESET != 0);
         r_cpu_ce  <= 1'b0;
      end else begin
         r_cpu_ce <= 1'b0;
         if (halt_req) begin
            // halt_req overrides ticks and both buttons in every state.
            r_state   <= HALTED;
            r_running <= 1'b0;
         end else begin
            case (r_state)
               HALTED: begin
                  if (w_run_press) begin
                     r_state   <= RUNNING;
                     r_running <= 1'b1;
                  end else if (w_step_press) begin
                     r_state <= STEP_ARMED;
                  end
               end
               RUNNING: begin
                  r_cpu_ce <= w_tick_edge & ~r_cpu_ce;
                  if (w_run_press) begin
                     r_state   <= HALTED;
                     r_running <= 1'b0;
                  end
               end
               STEP_ARMED: begin
                  if (w_run_press) begin
                     r_state   <= RUNNING;
                     r_running <= 1'b1;
                  end else if (w_tick_edge) begin
                     r_cpu_ce <= ~r_cpu_ce;
                     r_state  <= HALTED;
                  end
               end
               default: begin
                  r_state   <= HALTED;
                  r_running <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cpu_ce  = r_cpu_ce;
   assign running = r_running;

`ifdef CLKCTL_CYCLE_COUNT_EN
   logic [CYCLE_COUNT_W-1:0] r_cycle_count;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_cycle_count <= '0;
      end else if (r_cpu_ce) begin
         r_cycle_count <= r_cycle_count + 1'b1;
      end
   end

   assign cycle_count = r_cycle_count;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_clock_control.sv
// Directed self-checking bench for cpu_clock_control (DEBOUNCE_BITS=4, tick period 8 clk_in).
module tb_cpu_clock_control;
   import tiny16_pkg::*;

`ifdef CLKCTL_CYCLE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic                     clk_in = 1'b0;
   logic                     rst = 1'b1;
   logic                     tick_in = 1'b0;
   logic                     run_btn = 1'b0;
   logic                     step_btn = 1'b0;
   logic                     halt_req = 1'b0;
   logic                     cpu_ce;
   logic                     running;
   logic [CYCLE_COUNT_W-1:0] cycle_count;

   int checks = 0;
   int errors = 0;
   int ce_total = 0;
   logic prev_ce = 1'b0;

   cpu_clock_control #(.DEBOUNCE_BITS(4), .RUN_ON_RESET(0)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .tick_in     (tick_in),
      .run_btn     (run_btn),
      .step_btn    (step_btn),
      .halt_req    (halt_req),
      .cpu_ce      (cpu_ce),
      .running     (running),
      .cycle_count (cycle_count)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (cpu_ce) ce_total++;
      checks++;
      if (cpu_ce && prev_ce) begin
         errors++;
         $display("FAIL ce_back_to_back: cpu_ce high two cycles in a row at %0t (required single-cycle)", $time);
      end
      prev_ce = cpu_ce;
   end

   // One tick_in period; lat = posedge index (1..8) of first cpu_ce, 0 if none.
   task automatic tick_pulse(output int lat);
      lat = 0;
      @(negedge clk_in);
      tick_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk_in);
         #1;
         if (cpu_ce && lat == 0) lat = i;
         if (i == 4) tick_in = 1'b0;
      end
   endtask

   task automatic press_btn(input bit is_run, output int run_lat);
      run_lat = 0;
      @(negedge clk_in);
      if (is_run) run_btn = 1'b1; else step_btn = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk_in);
         #1;
         if (running && run_lat == 0) run_lat = i;
      end
      @(negedge clk_in);
      run_btn  = 1'b0;
      step_btn = 1'b0;
      repeat (25) @(negedge clk_in);
   endtask

   task automatic test_reset();
      int lat;
      int ce0;
      repeat (3) @(negedge clk_in);
      checks++;
      if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", cpu_ce); end
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
      checks++;
      if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
      rst = 1'b0;
      ce0 = ce_total;
      for (int k = 0; k < 12; k++) tick_pulse(lat);
      checks++;
      if (ce_total != ce0) begin errors++; $display("FAIL halted_idle_ce: got %0d pulses want 0", ce_total - ce0); end
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL halted_idle_running: got %b want 0", running); end
      checks++;
      if (cycle_count !== 32'd0) begin errors++; $display("FAIL halted_idle_count: got %0d want 0", cycle_count); end
   endtask

   task automatic test_run();
      int lat;
      int rl;
      int ce0;
      press_btn(1'b1, rl);
      checks++;
      if (rl == 0 || rl > 22) begin errors++; $display("FAIL run_latency: got %0d cycles want 1..22", rl); end
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL run_after_release: got %b want 1", running); end
      ce0 = ce_total;
      for (int k = 0; k < 10; k++) begin
         tick_pulse(lat);
         checks++;
         if (lat != 3) begin errors++; $display("FAIL run_tick%0d_latency: got %0d want 3", k, lat); end
      end
      repeat (3) @(negedge clk_in);
      checks++;
      if (ce_total - ce0 != 10) begin errors++; $display("FAIL run_pulse_count: got %0d want 10", ce_total - ce0); end
      checks++;
      if (cycle_count !== (CNT_EN ? 32'd10 : 32'd0))
         begin errors++; $display("FAIL run_cycle_count: got %0d want %0d", cycle_count, CNT_EN ? 10 : 0); end
   endtask

   task automatic test_halt_req();
      int ce0;
      ce0 = ce_total;
      @(negedge clk_in);
      tick_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk_in);
         #1;
         if (i == 2) halt_req = 1'b1;
         if (i == 3) begin
            halt_req = 1'b0;
            checks++;
            if (cpu_ce !== 1'b0) begin errors++; $display("FAIL halt_ce: got %b want 0", cpu_ce); end
            checks++;
            if (running !== 1'b0) begin errors++; $display("FAIL halt_running: got %b want 0", running); end
         end
         if (i == 4) tick_in = 1'b0;
      end
      checks++;
      if (ce_total != ce0) begin errors++; $display("FAIL halt_pulses: got %0d want 0", ce_total - ce0); end
   endtask

   task automatic test_step();
      int lat;
      int rl;
      int ce0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_in);
         step_btn = ~k[0];
      end
      @(negedge clk_in);
      step_btn = 1'b0;
      ce0 = ce_total;
      press_btn(1'b0, rl);
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL step_running: got %b want 0", running); end
      tick_pulse(lat);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL step_latency: got %0d want 3", lat); end
      tick_pulse(lat);
      checks++;
      if (lat != 0) begin errors++; $display("FAIL step_second_tick: got ce at %0d want none", lat); end
      checks++;
      if (ce_total - ce0 != 1) begin errors++; $display("FAIL step_pulses: got %0d want 1", ce_total - ce0); end
      checks++;
      if (cycle_count !== (CNT_EN ? 32'd11 : 32'd0))
         begin errors++; $display("FAIL step_cycle_count: got %0d want %0d", cycle_count, CNT_EN ? 11 : 0); end
   endtask

   task automatic test_step_reset();
      int lat;
      int rl;
      press_btn(1'b0, rl);
      @(negedge clk_in);
      rst = 1'b1;
      #1;
      checks++;
      if (cpu_ce !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b want 0", cpu_ce); end
      repeat (2) @(negedge clk_in);
      rst = 1'b0;
      tick_pulse(lat);
      checks++;
      if (lat != 0) begin errors++; $display("FAIL rst_abort_step: got ce at %0d want none", lat); end
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b want 0", running); end
      checks++;
      if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", cycle_count); end
   endtask

   task automatic test_wrap();
      int lat;
      int rl;
      press_btn(1'b0, rl);
`ifdef CLKCTL_CYCLE_COUNT_EN
      @(negedge clk_in);
      force dut.r_cycle_count = 32'hFFFF_FFFF;
      @(posedge clk_in);
      #1;
      release dut.r_cycle_count;
`endif
      tick_pulse(lat);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL wrap_step_latency: got %0d want 3", lat); end
      checks++;
      if (cycle_count !== 32'd0) begin errors++; $display("FAIL wrap_count: got %0h want 0", cycle_count); end
   endtask

   initial begin
      test_reset();
      test_run();
      test_halt_req();
      test_step();
      test_step_reset();
      test_wrap();
      repeat (4) @(negedge clk_in);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
